apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//   Single-outstanding APB4/APB5 requester. Converts a valid/ready command
//   channel into APB SETUP/ACCESS transfers on the master side of the APB
//   interface, and returns read data and status on a valid/ready response channel.
//   Sits directly upstream of APB completers. Drives every requester signal.
//   Samples pready/prdata/pslverr.
// PARAMETERS
//   ADDR_WIDTH      32   paddr / req_addr width
//   DATA_WIDTH      32   pwdata/prdata width; pstrb width = DATA_WIDTH/8
//   TIMEOUT_CYCLES  256  max ACCESS cycles without pready; 0 disables timeout
// PORTS
//   pclk         in   1             clock; all logic on rising edge
//   presetn      in   1             asynchronous active-low reset
//   req_valid    in   1             command valid
//   req_ready    out  1             command accepted when valid&ready
//   req_write    in   1             1=write, 0=read
//   req_addr     in   ADDR_WIDTH    transfer address
//   req_wdata    in   DATA_WIDTH    write data
//   req_strb     in   DATA_WIDTH/8  write byte strobes
//   req_prot     in   3             protection attributes
//   req_nse      in   1             non-secure extension
//   rsp_valid    out  1             response valid
//   rsp_ready    in   1             response consumed when valid&ready
//   rsp_rdata    out  DATA_WIDTH    read data (0 for writes/timeouts)
//   rsp_slverr   out  1             pslverr captured, or 1 on timeout
//   rsp_timeout  out  1             transfer aborted by timeout
//   paddr/pprot/pnse/psel/penable/pwrite/pwdata/pstrb  out  APB requester signals
//   pready/prdata/pslverr                              in   APB completer signals
// BEHAVIOUR
//   - Reset (presetn=0, async): state=IDLE. All outputs 0 except req_ready=1.
//     psel/penable drop immediately, including mid-transfer. No response is issued.
//   - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid, register command, go SETUP.
//     SETUP: psel=1, penable=0 for exactly one cycle, then go ACCESS.
//     ACCESS: psel=1, penable=1. pready=1 -> capture prdata (reads only) and
//     pslverr, go RESP. Otherwise stay; wait-state count increments.
//     RESP: rsp_valid=1, psel=penable=0. rsp_ready=1 -> IDLE.
//   - req_ready=1 only in IDLE. One transfer outstanding; no pipelining.
//   - paddr, pprot, pnse, pwrite, pwdata and pstrb come from registered command
//     and are stable from SETUP through the last ACCESS cycle.
//   - Reads: pstrb=0 and pwdata=0. Writes: rsp_rdata=0.
//   - pslverr is sampled only in the ACCESS cycle where pready=1.
//   - Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2.
//     With zero wait states, rsp_valid is asserted from N+3.
//     Each wait state adds one cycle.
//   - Timeout (TIMEOUT_CYCLES>0): ACCESS held for TIMEOUT_CYCLES cycles with
//     pready=0 -> go RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
//     psel/penable deassert the following cycle.
//     Wait counter is cleared on entering SETUP. Width is $clog2(TIMEOUT_CYCLES+1).
//   - Response fields hold stable while rsp_valid=1 && rsp_ready=0.
//   - After rsp handshake, next command earliest accepted one cycle later (IDLE).
//     So back-to-back transfers are separated by at least one idle APB cycle.
// TESTING
//   1. Read 0x0000_0010, pready=1 in first ACCESS, prdata=0xDEAD_BEEF
//      -> SETUP/ACCESS one cycle each, rsp_rdata=0xDEAD_BEEF, slverr=0, rsp_valid at N+3.
//   2. Write 0x0000_0020 data 0x1234_5678 strb 4'b0101, 3 wait states
//      -> pstrb=0101, signals stable 5 cycles, rsp_valid at N+6, rsp_rdata=0.
//   3. Read with pready=1, pslverr=1 -> rsp_slverr=1, rsp_timeout=0.
//   4. TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, then
//      psel=0, rsp_slverr=1, rsp_timeout=1.
//   5. rsp_ready=0 for 10 cycles -> rsp fields stable, req_ready=0.
//      Next req accepted only after handshake.
//   6. presetn low during ACCESS -> psel/penable=0 same cycle, rsp_valid=0.
//      After release, req_ready=1.

Source files
------------

// File: rtl/apb_requester.sv
// Single-outstanding APB4/APB5 requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns read data and status on a valid/ready response.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    input  logic                    req_nse,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pnse,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wait_q, wait_d;
    logic                   req_ready_d, rsp_valid_d, rsp_slverr_d, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_d, pwdata_d;
    logic [ADDR_WIDTH-1:0]  paddr_d;
    logic [2:0]             pprot_d;
    logic                   pnse_d, psel_d, penable_d, pwrite_d;
    logic [STRB_WIDTH-1:0]  pstrb_d;

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        req_ready_d   = req_ready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_slverr_d  = rsp_slverr;
        rsp_timeout_d = rsp_timeout;
        paddr_d       = paddr;
        pprot_d       = pprot;
        pnse_d        = pnse;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        pwdata_d      = pwdata;
        pstrb_d       = pstrb;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SETUP;
                    wait_d      = '0;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = req_addr;
                    pprot_d     = req_prot;
                    pnse_d      = req_nse;
                    pwrite_d    = req_write;
                    // Reads present zero data and strobes on the bus.
                    pwdata_d    = req_write ? req_wdata : '0;
                    pstrb_d     = req_write ? req_strb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_slverr_d  = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (TIMEOUT_CYCLES != 0 && wait_q == CNT_WIDTH'(TO_LAST)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_d = wait_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            pprot       <= '0;
            pnse        <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_slverr  <= rsp_slverr_d;
            rsp_timeout <= rsp_timeout_d;
            paddr       <= paddr_d;
            pprot       <= pprot_d;
            pnse        <= pnse_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            pwdata      <= pwdata_d;
            pstrb       <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: hand-derived vector table, reset/backpressure sequences,
// and random transfers checked against a transaction-level model.
module tb_apb_requester;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write, req_nse;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        pnse, psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int n_vec = 0;
    int n_err = 0;

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .req_nse(req_nse),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        int          waits;     // ACCESS cycles with pready=0 before completion
        logic        slverr;
        logic [31:0] rdata;
        int          stall;     // cycles rsp_ready stays low
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_timeout;
        int          exp_lat;   // cycles from accept edge to first rsp_valid
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation derived from the transfer rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic timed_out = (v.waits >= TO);
        int   acc = timed_out ? TO : v.waits + 1;
        r.exp_timeout = timed_out;
        r.exp_slverr  = timed_out ? 1'b1 : v.slverr;
        r.exp_rdata   = (timed_out || v.write) ? 32'h0 : v.rdata;
        r.exp_lat     = 2 + acc;
        return r;
    endfunction

    task automatic run_xfer(input vec_t v);
        int lat;
        int acc;
        logic got_rsp;
        logic [31:0] exp_wd = v.write ? v.wdata : 32'h0;
        logic [3:0]  exp_sb = v.write ? v.strb : 4'h0;
        logic [63:0] exp_ctl = {23'h0, v.addr, v.write, v.prot, v.nse, exp_sb};
        logic [34:0] rsp_snap;
        @(negedge pclk);
        check("idle_req_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        req_strb = v.strb; req_prot = v.prot; req_nse = v.nse;
        @(negedge pclk);
        lat = 1;
        req_valid = 1'b0;
        req_write = ~v.write; req_addr = ~v.addr; req_wdata = ~v.wdata; req_strb = ~v.strb;
        check("setup_phase", 64'({psel, penable, req_ready, rsp_valid}), 64'(4'b1000));
        check("setup_ctl", {23'h0, paddr, pwrite, pprot, pnse, pstrb}, exp_ctl);
        check("setup_wdata", 64'(pwdata), 64'(exp_wd));
        pready = 1'b0;
        acc = 0;
        got_rsp = 1'b0;
        while (!got_rsp && lat < 40) begin
            @(negedge pclk);
            lat++;
            if (rsp_valid) begin
                got_rsp = 1'b1;
            end else begin
                acc++;
                check("access_phase", 64'({psel, penable}), 64'(2'b11));
                check("access_ctl", {23'h0, paddr, pwrite, pprot, pnse, pstrb}, exp_ctl);
                check("access_wdata", 64'(pwdata), 64'(exp_wd));
                pready  = (acc - 1 == v.waits);
                prdata  = pready ? v.rdata : $urandom;
                pslverr = pready ? v.slverr : 1'($urandom);
            end
        end
        pready = 1'b0; pslverr = 1'b0;
        if (!got_rsp) begin
            check("rsp_wait_expired", 64'(0), 64'(1));
            return;
        end
        check("rsp_latency", 64'(lat), 64'(v.exp_lat));
        check("rsp_bus_idle", 64'({psel, penable, req_ready}), 64'(3'b000));
        check("rsp_fields", 64'({rsp_rdata, rsp_slverr, rsp_timeout}),
              64'({v.exp_rdata, v.exp_slverr, v.exp_timeout}));
        rsp_snap = {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout};
        for (int i = 0; i < v.stall; i++) begin
            req_valid = 1'b1;
            @(negedge pclk);
            check("stall_hold", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}), 64'(rsp_snap));
            check("stall_no_accept", 64'({req_ready, psel}), 64'(2'b00));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("post_handshake", 64'({rsp_valid, req_ready, psel}), 64'(3'b010));
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] sb, input int waits, input logic se,
                                input logic [31:0] rd, input int stall, input logic [31:0] erd,
                                input logic ese, input logic eto, input int elat);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = sb; v.prot = 3'b010; v.nse = 1'b1;
        v.waits = waits; v.slverr = se; v.rdata = rd; v.stall = stall;
        v.exp_rdata = erd; v.exp_slverr = ese; v.exp_timeout = eto; v.exp_lat = elat;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; req_nse = 1'b0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;

        vecs.push_back(mk(0, 32'h10, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 3));
        vecs.push_back(mk(1, 32'h20, 32'h1234_5678, 4'b0101, 3, 0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 6));
        vecs.push_back(mk(0, 32'h30, 32'h0, 4'hF, 0, 1, 32'hCAFE_0001, 0, 32'hCAFE_0001, 1, 0, 3));
        vecs.push_back(mk(0, 32'h40, 32'h0, 4'hF, 10, 0, 32'h5555_AAAA, 0, 32'h0, 1, 1, 6));
        vecs.push_back(mk(0, 32'h50, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D, 10, 32'h0BAD_F00D, 0, 0, 4));
        vecs.push_back(mk(1, 32'h60, 32'hA5A5_0000, 4'b1100, 2, 1, 32'h7777_7777, 2, 32'h0, 1, 0, 5));
        vecs.push_back(mk(1, 32'h70, 32'h0000_5A5A, 4'b0011, 7, 0, 32'h0, 0, 32'h0, 1, 1, 6));
        vecs.push_back(mk(0, 32'h80, 32'h0, 4'hF, 3, 0, 32'h1357_9BDF, 1, 32'h1357_9BDF, 0, 0, 6));

        repeat (2) @(negedge pclk);
        check("reset_ctl", 64'({req_ready, rsp_valid, psel, penable, rsp_slverr, rsp_timeout, pwrite, pnse}),
              64'(8'b1000_0000));
        check("reset_data", {paddr, rsp_rdata}, 64'(0));
        presetn = 1'b1;

        foreach (vecs[i]) run_xfer(vecs[i]);

        // Reset asserted mid-ACCESS drops the bus without a response.
        @(negedge pclk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h90; req_prot = 3'b001; req_nse = 1'b0;
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        check("pre_reset_access", 64'({psel, penable}), 64'(2'b11));
        #2 presetn = 1'b0;
        #1 check("reset_mid_access", 64'({psel, penable, rsp_valid, req_ready}), 64'(4'b0001));
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("after_reset_idle", 64'({req_ready, psel, penable, rsp_valid}), 64'(4'b1000));

        for (int k = 0; k < 30; k++) begin
            v.write = 1'($urandom); v.addr = $urandom; v.wdata = $urandom; v.strb = 4'($urandom);
            v.prot = 3'($urandom); v.nse = 1'($urandom);
            v.waits = $urandom_range(0, 6); v.slverr = 1'($urandom); v.rdata = $urandom;
            v.stall = $urandom_range(0, 3);
            run_xfer(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
